// File: rtl/wb_arbiter_2m.sv
// Two-master to one-slave pipelined Wishbone arbiter.
// Round-robin grant is held for a whole CYC. Outstanding requests are counted
// and capped at MAX_OUT. A watchdog aborts a hung slave by returning ERR.
module wb_arbiter_2m #(
  parameter int unsigned AW      = 30,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  output logic [DW-1:0]   o_a_data,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_b_data,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [AW-1:0]   o_s_addr,
  output logic [DW-1:0]   o_s_data,
  output logic [DW/8-1:0] o_s_sel,
  input  logic            i_s_stall,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  input  logic [DW-1:0]   i_s_data
);

  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_A = 2'd1,
    ST_GNT_B = 2'd2,
    ST_ABORT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            last_b_q, last_b_d;   // 1: B was granted last
  logic [OW-1:0]   out_q, out_d;
  logic [TW-1:0]   wdog_q, wdog_d;

  logic gnt_a, gnt_b, gnt, abort;
  logic x_cyc, x_stb, full, accept, retire;

  // Grant decode and slave-side request mux
  assign gnt_a    = (state_q == ST_GNT_A);
  assign gnt_b    = (state_q == ST_GNT_B);
  assign gnt      = gnt_a | gnt_b;
  assign abort    = (state_q == ST_ABORT);
  assign x_cyc    = gnt_b ? i_b_cyc : i_a_cyc;
  assign x_stb    = gnt_b ? i_b_stb : i_a_stb;
  assign full     = (out_q == OW'(MAX_OUT));

  assign o_s_cyc  = gnt & x_cyc;
  assign o_s_stb  = gnt & x_cyc & x_stb & ~full;
  assign o_s_we   = gnt_b ? i_b_we   : i_a_we;
  assign o_s_addr = gnt_b ? i_b_addr : i_a_addr;
  assign o_s_data = gnt_b ? i_b_data : i_a_data;
  assign o_s_sel  = gnt_b ? i_b_sel  : i_a_sel;

  assign accept   = o_s_stb & ~i_s_stall;
  assign retire   = gnt & (i_s_ack | i_s_err);

  // Master-side responses; the aborted master is the one granted last
  assign o_a_stall = gnt_a ? (i_s_stall | full) : 1'b1;
  assign o_b_stall = gnt_b ? (i_s_stall | full) : 1'b1;
  assign o_a_ack   = gnt_a & i_s_ack;
  assign o_b_ack   = gnt_b & i_s_ack;
  assign o_a_err   = (gnt_a & i_s_err) | (abort & ~last_b_q);
  assign o_b_err   = (gnt_b & i_s_err) | (abort &  last_b_q);
  assign o_a_data  = i_s_data;
  assign o_b_data  = i_s_data;

  // Next-state: arbitration, outstanding count and watchdog
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    out_d    = out_q;
    wdog_d   = wdog_q;
    case (state_q)
      ST_IDLE: begin
        out_d  = '0;
        wdog_d = '0;
        if (i_a_cyc && (!i_b_cyc || last_b_q)) begin
          state_d  = ST_GNT_A;
          last_b_d = 1'b0;
        end else if (i_b_cyc) begin
          state_d  = ST_GNT_B;
          last_b_d = 1'b1;
        end
      end
      ST_GNT_A, ST_GNT_B: begin
        if (!x_cyc) begin
          state_d = ST_IDLE;
          out_d   = '0;
          wdog_d  = '0;
        end else begin
          out_d = out_q + OW'(accept) - OW'(retire && (out_q != '0));
          if (retire || (out_q == '0)) begin
            wdog_d = '0;
          end else if (wdog_q == TW'(TIMEOUT - 1)) begin
            state_d = ST_ABORT;
          end else begin
            wdog_d = wdog_q + TW'(1);
          end
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        out_d   = '0;
        wdog_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      last_b_q <= 1'b1;
      out_q    <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      out_q    <= out_d;
      wdog_q   <= wdog_d;
    end
  end

endmodule
